axi_master_router: RTL and testbench

Address-decoding 1-to-N AXI4 router that sits directly downstream of `axi_slave_router`. It consumes that block's single arbitrated M_AXI port and steers each transaction to one of `AXI_SLAVE_PORT` slave-side ports, selected by the top address bits. Responses from the addressed port are returned upstream. Unmapped addresses are terminated locally with DECERR. The block supports one outstanding write and one outstanding read, handled by independent state machines.

---
 rtl/axi_master_router.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi_master_router.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_router.sv
// axi_master_router: 1-to-N AXI4 address-decoding router.
// One outstanding write and one outstanding read; unmapped -> DECERR.
module axi_master_router #(
  parameter int AXI_ID_WIDTH     = 1,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_ADDR_WIDTH   = 8,
  parameter int AXI_SLAVE_PORT   = 2,
  parameter int SEL_BITS         = 1,
  parameter int AXI_AWCHAN_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
  parameter int AXI_ARCHAN_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 13,
  parameter int AXI_WDCHAN_WIDTH = AXI_DATA_WIDTH + AXI_DATA_WIDTH/8 + 1,
  parameter int AXI_WBCHAN_WIDTH = AXI_ID_WIDTH + 2,
  parameter int AXI_RDCHAN_WIDTH = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic [2:0]                  S_AXI_AWSIZE,
  input  logic [1:0]                  S_AXI_AWBURST,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WLAST,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic [2:0]                  S_AXI_ARSIZE,
  input  logic [1:0]                  S_AXI_ARBURST,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [AXI_AWCHAN_WIDTH*AXI_SLAVE_PORT-1:0] M_AXI_AWCH_o,
  output logic [AXI_SLAVE_PORT-1:0]   M_AXI_AWCH_VALID_o,
  input  logic [AXI_SLAVE_PORT-1:0]   M_AXI_AWCH_READY_i,
  output logic [AXI_WDCHAN_WIDTH*AXI_SLAVE_PORT-1:0] M_AXI_WCH_o,
  output logic [AXI_SLAVE_PORT-1:0]   M_AXI_WCH_VALID_o,
  input  logic [AXI_SLAVE_PORT-1:0]   M_AXI_WCH_READY_i,
  input  logic [AXI_WBCHAN_WIDTH*AXI_SLAVE_PORT-1:0] M_AXI_BCH_i,
  input  logic [AXI_SLAVE_PORT-1:0]   M_AXI_BCH_VALID_i,
  output logic [AXI_SLAVE_PORT-1:0]   M_AXI_BCH_READY_o,
  output logic [AXI_ARCHAN_WIDTH*AXI_SLAVE_PORT-1:0] M_AXI_ARCH_o,
  output logic [AXI_SLAVE_PORT-1:0]   M_AXI_ARCH_VALID_o,
  input  logic [AXI_SLAVE_PORT-1:0]   M_AXI_ARCH_READY_i,
  input  logic [AXI_RDCHAN_WIDTH*AXI_SLAVE_PORT-1:0] M_AXI_RCH_i,
  input  logic [AXI_SLAVE_PORT-1:0]   M_AXI_RCH_VALID_i,
  output logic [AXI_SLAVE_PORT-1:0]   M_AXI_RCH_READY_o
);

  localparam int N   = AXI_SLAVE_PORT;
  localparam int IDW = AXI_ID_WIDTH;
  localparam int AWW = AXI_AWCHAN_WIDTH;
  localparam int ARW = AXI_ARCHAN_WIDTH;
  localparam int WW  = AXI_WDCHAN_WIDTH;
  localparam int BW  = AXI_WBCHAN_WIDTH;
  localparam int RW  = AXI_RDCHAN_WIDTH;
  localparam int SW  = SEL_BITS + 1;
  localparam logic [SEL_BITS:0] NP = SW'(AXI_SLAVE_PORT);

  typedef enum logic [2:0] {
    W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR_DATA, W_ERR_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE, R_ADDR, R_DATA, R_ERR
  } r_state_t;

  w_state_t wr_st;
  r_state_t rd_st;

  logic                aw_rdy, ar_rdy;
  logic [AWW-1:0]      aw_q;
  logic [ARW-1:0]      ar_q;
  logic [SEL_BITS-1:0] aw_idx, ar_idx;
  logic [SEL_BITS-1:0] aw_sel, ar_sel;
  logic                aw_hit, ar_hit;
  logic                aw_go, ar_go;
  logic [7:0]          r_cnt;
  logic [IDW-1:0]      aw_id, ar_id;
  logic [7:0]          ar_len;

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_ARREADY = ar_rdy;
  assign aw_sel = S_AXI_AWADDR[AXI_ADDR_WIDTH-1 -: SEL_BITS];
  assign ar_sel = S_AXI_ARADDR[AXI_ADDR_WIDTH-1 -: SEL_BITS];
  assign aw_hit = {1'b0, aw_sel} < NP;
  assign ar_hit = {1'b0, ar_sel} < NP;
  assign aw_id  = aw_q[AWW-1 -: IDW];
  assign ar_id  = ar_q[ARW-1 -: IDW];
  assign ar_len = ar_q[AXI_ADDR_WIDTH+5 +: 8];

  // Write FSM: accepts AW, routes W, returns B (or local DECERR).
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_st  <= W_IDLE;
      aw_rdy <= 1'b0;
      aw_q   <= '0;
      aw_idx <= '0;
    end else begin
      case (wr_st)
        W_IDLE: begin
          aw_rdy <= 1'b1;
          if (aw_rdy && S_AXI_AWVALID) begin
            aw_rdy <= 1'b0;
            aw_idx <= aw_sel;
            aw_q   <= {S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE,
                       S_AXI_AWBURST, S_AXI_AWADDR};
            wr_st  <= aw_hit ? W_ADDR : W_ERR_DATA;
          end
        end
        W_ADDR:
          if (aw_go) wr_st <= W_DATA;
        W_DATA:
          if (S_AXI_WVALID && S_AXI_WREADY && S_AXI_WLAST)
            wr_st <= W_RESP;
        W_RESP:
          if (S_AXI_BVALID && S_AXI_BREADY) begin
            wr_st  <= W_IDLE;
            aw_rdy <= 1'b1;
          end
        W_ERR_DATA:
          if (S_AXI_WVALID && S_AXI_WLAST) wr_st <= W_ERR_RESP;
        W_ERR_RESP:
          if (S_AXI_BREADY) begin
            wr_st  <= W_IDLE;
            aw_rdy <= 1'b1;
          end
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  // Write-side steering: only port aw_idx sees any VALID/READY.
  always_comb begin
    M_AXI_AWCH_o       = '0;
    M_AXI_AWCH_VALID_o = '0;
    M_AXI_WCH_o        = '0;
    M_AXI_WCH_VALID_o  = '0;
    M_AXI_BCH_READY_o  = '0;
    S_AXI_WREADY       = 1'b0;
    S_AXI_BVALID       = 1'b0;
    S_AXI_BRESP        = '0;
    S_AXI_BID          = '0;
    aw_go              = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (aw_idx == SEL_BITS'(k)) begin
        if (wr_st == W_ADDR) begin
          M_AXI_AWCH_o[k*AWW +: AWW] = aw_q;
          M_AXI_AWCH_VALID_o[k]      = 1'b1;
          aw_go                      = M_AXI_AWCH_READY_i[k];
        end
        if (wr_st == W_DATA) begin
          M_AXI_WCH_o[k*WW +: WW] =
            {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST};
          M_AXI_WCH_VALID_o[k] = S_AXI_WVALID;
          S_AXI_WREADY         = M_AXI_WCH_READY_i[k];
        end
        if (wr_st == W_RESP) begin
          {S_AXI_BRESP, S_AXI_BID} = M_AXI_BCH_i[k*BW +: BW];
          S_AXI_BVALID             = M_AXI_BCH_VALID_i[k];
          M_AXI_BCH_READY_o[k]     = S_AXI_BREADY;
        end
      end
    end
    if (wr_st == W_ERR_DATA) S_AXI_WREADY = 1'b1;
    if (wr_st == W_ERR_RESP) begin
      S_AXI_BVALID = 1'b1;
      S_AXI_BRESP  = 2'b11;
      S_AXI_BID    = aw_id;
    end
  end

  // Read FSM: accepts AR, routes R, or generates ARLEN+1 DECERR beats.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_st  <= R_IDLE;
      ar_rdy <= 1'b0;
      ar_q   <= '0;
      ar_idx <= '0;
      r_cnt  <= '0;
    end else begin
      case (rd_st)
        R_IDLE: begin
          ar_rdy <= 1'b1;
          if (ar_rdy && S_AXI_ARVALID) begin
            ar_rdy <= 1'b0;
            ar_idx <= ar_sel;
            r_cnt  <= '0;
            ar_q   <= {S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE,
                       S_AXI_ARBURST, S_AXI_ARADDR};
            rd_st  <= ar_hit ? R_ADDR : R_ERR;
          end
        end
        R_ADDR:
          if (ar_go) rd_st <= R_DATA;
        R_DATA:
          if (S_AXI_RVALID && S_AXI_RREADY && S_AXI_RLAST) begin
            rd_st  <= R_IDLE;
            ar_rdy <= 1'b1;
          end
        R_ERR:
          if (S_AXI_RREADY) begin
            if (r_cnt == ar_len) begin
              rd_st  <= R_IDLE;
              ar_rdy <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        default: rd_st <= R_IDLE;
      endcase
    end
  end

  // Read-side steering and local error beat generation.
  always_comb begin
    M_AXI_ARCH_o       = '0;
    M_AXI_ARCH_VALID_o = '0;
    M_AXI_RCH_READY_o  = '0;
    S_AXI_RVALID       = 1'b0;
    S_AXI_RDATA        = '0;
    S_AXI_RRESP        = '0;
    S_AXI_RLAST        = 1'b0;
    S_AXI_RID          = '0;
    ar_go              = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (ar_idx == SEL_BITS'(k)) begin
        if (rd_st == R_ADDR) begin
          M_AXI_ARCH_o[k*ARW +: ARW] = ar_q;
          M_AXI_ARCH_VALID_o[k]      = 1'b1;
          ar_go                      = M_AXI_ARCH_READY_i[k];
        end
        if (rd_st == R_DATA) begin
          {S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RID} =
            M_AXI_RCH_i[k*RW +: RW];
          S_AXI_RVALID         = M_AXI_RCH_VALID_i[k];
          M_AXI_RCH_READY_o[k] = S_AXI_RREADY;
        end
      end
    end
    if (rd_st == R_ERR) begin
      S_AXI_RVALID = 1'b1;
      S_AXI_RRESP  = 2'b11;
      S_AXI_RLAST  = (r_cnt == ar_len);
      S_AXI_RID    = ar_id;
    end
  end

endmodule

// File: tb/tb_axi_master_router.sv
// tb_axi_master_router: directed bench for axi_master_router.
// Three ports, two select bits: 0xC0..0xFF decode to DECERR.
module tb_axi_master_router;

  localparam int N   = 3;
  localparam int AWW = 22;
  localparam int WW  = 37;
  localparam int BW  = 3;
  localparam int RW  = 36;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic awid, awvalid, awready;
  logic [7:0] awaddr, awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready;
  logic bid, bvalid, bready;
  logic [1:0] bresp;
  logic arid, arvalid, arready;
  logic [7:0] araddr, arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic rid, rlast, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic [AWW*N-1:0] m_awch;
  logic [N-1:0] m_awv, m_awready;
  logic [WW*N-1:0] m_wch;
  logic [N-1:0] m_wv, m_wready;
  logic [BW*N-1:0] m_bch;
  logic [N-1:0] m_bvalid, m_bready;
  logic [AWW*N-1:0] m_arch;
  logic [N-1:0] m_arv, m_arready;
  logic [RW*N-1:0] m_rch;
  logic [N-1:0] m_rvalid, m_rready;

  axi_master_router #(
    .AXI_SLAVE_PORT(N),
    .SEL_BITS(2)
  ) u_dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr),
    .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr),
    .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .M_AXI_AWCH_o(m_awch), .M_AXI_AWCH_VALID_o(m_awv),
    .M_AXI_AWCH_READY_i(m_awready),
    .M_AXI_WCH_o(m_wch), .M_AXI_WCH_VALID_o(m_wv),
    .M_AXI_WCH_READY_i(m_wready),
    .M_AXI_BCH_i(m_bch), .M_AXI_BCH_VALID_i(m_bvalid),
    .M_AXI_BCH_READY_o(m_bready),
    .M_AXI_ARCH_o(m_arch), .M_AXI_ARCH_VALID_o(m_arv),
    .M_AXI_ARCH_READY_i(m_arready),
    .M_AXI_RCH_i(m_rch), .M_AXI_RCH_VALID_i(m_rvalid),
    .M_AXI_RCH_READY_o(m_rready)
  );

  int checks = 0;
  int errors = 0;
  logic [AWW-1:0] aw_exp, ar_exp;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic id, input logic [7:0] a,
                       input logic [7:0] len);
    awid = id; awaddr = a; awlen = len;
    awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    aw_exp = {id, len, 3'd2, 2'd1, a};
    #1 chk("awready", awready, 1);
    tick();
    awvalid = 1'b0;
    #1;
  endtask

  task automatic do_ar(input logic id, input logic [7:0] a,
                       input logic [7:0] len);
    arid = id; araddr = a; arlen = len;
    arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    ar_exp = {id, len, 3'd2, 2'd1, a};
    #1 chk("arready", arready, 1);
    tick();
    arvalid = 1'b0;
    #1;
  endtask

  task automatic aw_stage(input int k);
    chk("awvalid", m_awv, 3'(1 << k));
    chk("awch", m_awch[k*AWW +: AWW], aw_exp);
    chk("awready_busy", awready, 0);
    m_awready = 3'(1 << k);
    #1 tick();
    m_awready = '0;
  endtask

  task automatic ar_stage(input int k);
    chk("arvalid", m_arv, 3'(1 << k));
    chk("arch", m_arch[k*AWW +: AWW], ar_exp);
    chk("arready_busy", arready, 0);
    m_arready = 3'(1 << k);
    #1 tick();
    m_arready = '0;
  endtask

  task automatic wbeat(input int k, input logic [31:0] d,
                       input logic last);
    wdata = d; wstrb = 4'hF; wlast = last; wvalid = 1'b1;
    m_wready = (k >= 0) ? 3'(1 << k) : 3'b000;
    #1;
    chk("wvalid_route", m_wv, m_wready);
    chk("wready", wready, 1);
    if (k >= 0) chk("wch", m_wch[k*WW +: WW], {d, 4'hF, last});
    tick();
    wvalid = 1'b0; wlast = 1'b0; m_wready = '0;
  endtask

  task automatic bresp_ok(input int k, input logic id);
    m_bvalid = 3'(1 << k);
    m_bch = '0;
    m_bch[k*BW +: BW] = {2'b00, id};
    bready = 1'b1;
    #1;
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, 0);
    chk("bready_route", m_bready, 3'(1 << k));
    tick();
    m_bvalid = '0; m_bch = '0; bready = 1'b0;
    #1 chk("awready_idle", awready, 1);
  endtask

  initial begin
    int j, k, n, last_at;
    logic done;
    rst_n = 1'b0;
    {awid, awvalid, awaddr, awlen, awsize, awburst} = '0;
    {wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, arvalid, araddr, arlen, arsize, arburst} = '0;
    rready = 1'b0;
    m_awready = '0; m_wready = '0; m_bch = '0; m_bvalid = '0;
    m_arready = '0; m_rch = '0; m_rvalid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_awv", m_awv, 0);
    chk("rst_arv", m_arv, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_awready", awready, 1);
    chk("rel_arready", arready, 1);

    // write, port 0, 4 beats
    do_aw(1'b1, 8'h10, 8'd3);
    aw_stage(0);
    for (int i = 0; i < 4; i++) wbeat(0, 32'hA0 + i, i == 3);
    bresp_ok(0, 1'b1);

    // read, port 1, 8 beats, RREADY toggling
    do_ar(1'b1, 8'h40, 8'd7);
    ar_stage(1);
    j = 0; k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      m_rvalid = 3'b010;
      m_rch = '0;
      m_rch[RW +: RW] = {32'h100 + j, 2'b00, (j == 7), 1'b1};
      rready = (c % 2 == 0);
      #1;
      chk("r_rvalid", rvalid, 1);
      chk("r_rready_route", m_rready, rready ? 3'b010 : 3'b000);
      if (rready) begin
        chk("r_data", rdata, 32'h100 + k);
        chk("r_last", rlast, k == 7);
        chk("r_id", rid, 1);
        k++;
      end
      if (m_rready[1]) j++;
      tick();
    end
    m_rvalid = '0; rready = 1'b0;
    #1;
    chk("r_beats", k, 8);
    chk("r_arready_idle", arready, 1);

    // unmapped write, 2 beats
    do_aw(1'b0, 8'hC0, 8'd1);
    chk("err_awv", m_awv, 0);
    wbeat(-1, 32'h55, 1'b0);
    wbeat(-1, 32'h66, 1'b1);
    bready = 1'b0;
    #1;
    chk("err_bvalid", bvalid, 1);
    chk("err_bresp", bresp, 2'b11);
    chk("err_bid", bid, 0);
    chk("err_bready_route", m_bready, 0);
    tick();
    chk("err_bhold", bvalid, 1);
    bready = 1'b1;
    #1 tick();
    bready = 1'b0;
    #1;
    chk("err_bdone", bvalid, 0);
    chk("err_awready", awready, 1);

    // unmapped read, 3 beats, one stall first
    do_ar(1'b0, 8'hC0, 8'd2);
    chk("err_arv", m_arv, 0);
    rready = 1'b0;
    #1;
    chk("err_rvalid", rvalid, 1);
    chk("err_rlast_stall", rlast, 0);
    tick();
    for (int b = 0; b < 3; b++) begin
      rready = 1'b1;
      #1;
      chk("err_rdata", rdata, 0);
      chk("err_rresp", rresp, 2'b11);
      chk("err_rid", rid, 0);
      chk("err_rlast", rlast, b == 2);
      tick();
    end
    rready = 1'b0;
    #1;
    chk("err_rdone", rvalid, 0);
    chk("err_arready", arready, 1);

    // unmapped read, ARLEN=255
    do_ar(1'b1, 8'hE0, 8'd255);
    n = 0; last_at = -1; done = 1'b0; rready = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (rvalid) begin
        if (rlast && last_at < 0) last_at = n;
        done = rlast;
        n++;
      end
      tick();
    end
    rready = 1'b0;
    #1;
    chk("len255_beats", n, 256);
    chk("len255_last", last_at, 255);
    chk("len255_arready", arready, 1);

    // concurrent write port 0 and read port 1
    awid = 1'b1; awaddr = 8'h20; awlen = 8'd0;
    awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    arid = 1'b0; araddr = 8'h50; arlen = 8'd1;
    arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    aw_exp = {1'b1, 8'd0, 3'd2, 2'd1, 8'h20};
    ar_exp = {1'b0, 8'd1, 3'd2, 2'd1, 8'h50};
    #1;
    chk("cc_awready", awready, 1);
    chk("cc_arready", arready, 1);
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    #1;
    fork
      begin : wr_thread
        for (int i = 0; i < 5; i++) begin
          chk("cc_aw_hold", m_awv, 3'b001);
          chk("cc_awch", m_awch[0 +: AWW], aw_exp);
          tick();
        end
        m_awready = 3'b001;
        #1 tick();
        m_awready = '0;
        wbeat(0, 32'hDEADBEEF, 1'b1);
        bresp_ok(0, 1'b1);
      end
      begin : rd_thread
        chk("cc_arv", m_arv, 3'b010);
        chk("cc_arch", m_arch[AWW +: AWW], ar_exp);
        m_arready = 3'b010;
        #1 tick();
        m_arready = '0;
        for (int b = 0; b < 2; b++) begin
          m_rvalid = 3'b010;
          m_rch = '0;
          m_rch[RW +: RW] = {32'h200 + b, 2'b00, (b == 1), 1'b0};
          rready = 1'b1;
          #1;
          chk("cc_rvalid", rvalid, 1);
          chk("cc_rdata", rdata, 32'h200 + b);
          chk("cc_rlast", rlast, b == 1);
          chk("cc_rid", rid, 0);
          tick();
        end
        m_rvalid = '0; rready = 1'b0;
        #1 chk("cc_arready_idle", arready, 1);
      end
    join

    // reset during W beat 2, then a clean write to port 1
    do_aw(1'b1, 8'h30, 8'd3);
    aw_stage(0);
    wbeat(0, 32'h11, 1'b0);
    wdata = 32'h22; wstrb = 4'hF; wvalid = 1'b1;
    m_wready = 3'b001;
    #1 chk("rst_mid_wv", m_wv, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wv0", m_wv, 0);
    chk("rst_mid_wready", wready, 0);
    chk("rst_mid_awready", awready, 0);
    chk("rst_mid_arready", arready, 0);
    chk("rst_mid_awv", m_awv, 0);
    chk("rst_mid_bvalid", bvalid, 0);
    wvalid = 1'b0; m_wready = '0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rel_awready", awready, 1);
    do_aw(1'b1, 8'h40, 8'd0);
    aw_stage(1);
    wbeat(1, 32'h33, 1'b1);
    bresp_ok(1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
